// File: rtl/otp_pkg.sv
// Shared definitions for the OTP programming sequencer.
//   MODE_*  : encodings driven on fsm_mode towards the OTP controller
//   state_t : sequencer state encoding
package otp_pkg;

  localparam logic [1:0] MODE_IDLE = 2'd0;
  localparam logic [1:0] MODE_PROG = 2'd1;
  localparam logic [1:0] MODE_READ = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    PREREAD,
    PROG,
    VERIFY,
    RESP
  } state_t;

endpackage

// File: rtl/otp_cycle_timer.sv
// Loadable down-counter shared by the program-pulse length and the read
// timeout. Loading N makes 'expired' rise N cycles later; the count parks
// at zero once it gets there.
//   clk, reset : clock and synchronous active-high reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : value to load
//   expired    : count is zero
module otp_cycle_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/otp_prog_sequencer.sv
// OTP programming sequencer. Accepts read/program requests, pre-reads the
// target column, issues up to MAX_RETRY program pulses of PULSE_CYCLES each
// (only on bits still unset), verifies after each pulse, and returns one
// response per request.
//   req_*    : request handshake (op 0 = read, 1 = program), column, data
//   rsp_*    : response handshake with read-back word, fail flag, pulse count
//   fsm_*    : interface to the OTP controller (mode, column, data_in,
//              writing_successful strobe; read_active / data_out back)
// All outputs are registered except req_ready, decoded from the state.
module otp_prog_sequencer
  import otp_pkg::*;
#(
  parameter int A            = 2,
  parameter int B            = 2,
  parameter int PULSE_CYCLES = 8,
  parameter int MAX_RETRY    = 3,
  parameter int READ_TIMEOUT = 16,
  localparam int ADDR_WIDTH  = $clog2(B),
  localparam int PW          = $clog2(MAX_RETRY + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic [ADDR_WIDTH-1:0] req_column,
  input  logic [A-1:0]          req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [A-1:0]          rsp_data,
  output logic                  rsp_fail,
  output logic [PW-1:0]         rsp_pulses,
  output logic [1:0]            fsm_mode,
  output logic [ADDR_WIDTH-1:0] fsm_column,
  output logic [A-1:0]          fsm_data_in,
  output logic                  fsm_writing_successful,
  input  logic                  fsm_read_active,
  input  logic [A-1:0]          fsm_data_out
);

  localparam int TMAX = (PULSE_CYCLES > READ_TIMEOUT) ? PULSE_CYCLES : READ_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  // The timer is loaded with N-1 so that a state lasts exactly N cycles:
  // the last cycle is the one in which the timer reads zero.
  localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] READ_LOAD  = TW'(READ_TIMEOUT - 1);
  localparam logic [PW-1:0] RETRY_MAX  = PW'(MAX_RETRY);

  state_t                state;
  logic                  op_q;
  logic [A-1:0]          data_q;
  logic [PW-1:0]         pulses_q;

  logic                  t_load;
  logic [TW-1:0]         t_val;
  logic                  t_expired;

  logic                  covered;
  logic                  unprog;
  logic [A-1:0]          mask;
  logic                  pre_to_prog;
  logic                  verify_retry;

  // Every requested bit already reads back as 1.
  function automatic logic covers(input logic [A-1:0] sample, input logic [A-1:0] want);
    return (sample & want) == want;
  endfunction

  // A set bit that the request wants clear can never be undone on OTP.
  function automatic logic blocked(input logic [A-1:0] sample, input logic [A-1:0] want);
    return |(sample & ~want);
  endfunction

  assign covered      = covers(fsm_data_out, data_q);
  assign unprog       = blocked(fsm_data_out, data_q);
  assign mask         = data_q & ~fsm_data_out;
  assign pre_to_prog  = op_q && !unprog && !covered;
  assign verify_retry = !covered && (pulses_q < RETRY_MAX);

  assign req_ready = (state == IDLE);

  // Timer loads mirror the FSM transitions into PREREAD/VERIFY/PROG.
  always_comb begin
    t_load = 1'b0;
    t_val  = READ_LOAD;
    case (state)
      IDLE: begin
        if (req_valid) begin
          t_load = 1'b1;
          t_val  = READ_LOAD;
        end
      end
      PREREAD: begin
        if (fsm_read_active && pre_to_prog) begin
          t_load = 1'b1;
          t_val  = PULSE_LOAD;
        end
      end
      PROG: begin
        if (t_expired) begin
          t_load = 1'b1;
          t_val  = READ_LOAD;
        end
      end
      VERIFY: begin
        if (fsm_read_active && verify_retry) begin
          t_load = 1'b1;
          t_val  = PULSE_LOAD;
        end
      end
      default: begin
        t_load = 1'b0;
        t_val  = READ_LOAD;
      end
    endcase
  end

  otp_cycle_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .expired  (t_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state                  <= IDLE;
      op_q                   <= 1'b0;
      data_q                 <= '0;
      pulses_q               <= '0;
      rsp_valid              <= 1'b0;
      rsp_data               <= '0;
      rsp_fail               <= 1'b0;
      rsp_pulses             <= '0;
      fsm_mode               <= MODE_IDLE;
      fsm_column             <= '0;
      fsm_data_in            <= '0;
      fsm_writing_successful <= 1'b0;
    end else begin
      fsm_writing_successful <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q       <= req_op;
            data_q     <= req_data;
            pulses_q   <= '0;
            fsm_column <= req_column;
            fsm_mode   <= MODE_READ;
            state      <= PREREAD;
          end
        end

        PREREAD: begin
          if (fsm_read_active) begin
            if (pre_to_prog) begin
              fsm_mode    <= MODE_PROG;
              fsm_data_in <= mask;
              state       <= PROG;
            end else begin
              // Plain read, already-programmed word, or unprogrammable word.
              fsm_mode   <= MODE_IDLE;
              rsp_valid  <= 1'b1;
              rsp_data   <= fsm_data_out;
              rsp_fail   <= op_q && unprog;
              rsp_pulses <= '0;
              state      <= RESP;
            end
          end else if (t_expired) begin
            fsm_mode   <= MODE_IDLE;
            rsp_valid  <= 1'b1;
            rsp_data   <= '0;
            rsp_fail   <= 1'b1;
            rsp_pulses <= '0;
            state      <= RESP;
          end
        end

        PROG: begin
          if (t_expired) begin
            pulses_q    <= pulses_q + 1'b1;
            fsm_mode    <= MODE_READ;
            fsm_data_in <= '0;
            state       <= VERIFY;
          end
        end

        VERIFY: begin
          if (fsm_read_active) begin
            if (covered) begin
              fsm_writing_successful <= 1'b1;
              fsm_mode   <= MODE_IDLE;
              rsp_valid  <= 1'b1;
              rsp_data   <= fsm_data_out;
              rsp_fail   <= 1'b0;
              rsp_pulses <= pulses_q;
              state      <= RESP;
            end else if (verify_retry) begin
              // Re-pulse only the bits that still read back as 0.
              fsm_mode    <= MODE_PROG;
              fsm_data_in <= mask;
              state       <= PROG;
            end else begin
              fsm_mode   <= MODE_IDLE;
              rsp_valid  <= 1'b1;
              rsp_data   <= fsm_data_out;
              rsp_fail   <= 1'b1;
              rsp_pulses <= pulses_q;
              state      <= RESP;
            end
          end else if (t_expired) begin
            fsm_mode   <= MODE_IDLE;
            rsp_valid  <= 1'b1;
            rsp_data   <= '0;
            rsp_fail   <= 1'b1;
            rsp_pulses <= pulses_q;
            state      <= RESP;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_fail   <= 1'b0;
            rsp_pulses <= '0;
            state      <= IDLE;
          end
        end

        default: begin
          fsm_mode <= MODE_IDLE;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_otp_prog_sequencer.sv
// Directed bench for otp_prog_sequencer with a scripted OTP controller.
module tb_otp_prog_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic       req_op;
  logic [0:0] req_column;
  logic [1:0] req_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_data;
  logic       rsp_fail;
  logic [1:0] rsp_pulses;
  logic [1:0] fsm_mode;
  logic [0:0] fsm_column;
  logic [1:0] fsm_data_in;
  logic       fsm_writing_successful;
  logic       fsm_read_active;
  logic [1:0] fsm_data_out;

  always #5 clk = ~clk;

  otp_prog_sequencer #(
    .A            (2),
    .B            (2),
    .PULSE_CYCLES (8),
    .MAX_RETRY    (3),
    .READ_TIMEOUT (16)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .req_valid              (req_valid),
    .req_ready              (req_ready),
    .req_op                 (req_op),
    .req_column             (req_column),
    .req_data               (req_data),
    .rsp_valid              (rsp_valid),
    .rsp_ready              (rsp_ready),
    .rsp_data               (rsp_data),
    .rsp_fail               (rsp_fail),
    .rsp_pulses             (rsp_pulses),
    .fsm_mode               (fsm_mode),
    .fsm_column             (fsm_column),
    .fsm_data_in            (fsm_data_in),
    .fsm_writing_successful (fsm_writing_successful),
    .fsm_read_active        (fsm_read_active),
    .fsm_data_out           (fsm_data_out)
  );

  // Scripted controller: answers every read cycle immediately with the next
  // scripted word while enabled.
  logic [1:0] rd_vals [8];
  int         rd_cnt  = 0;
  int         rd_base = 0;
  logic       resp_en = 1'b1;

  assign fsm_read_active = resp_en && (fsm_mode == 2'd2);
  assign fsm_data_out    = rd_vals[(rd_cnt - rd_base) & 7];

  always @(posedge clk)
    if (!reset && fsm_mode == 2'd2 && fsm_read_active) rd_cnt <= rd_cnt + 1;

  // Activity counters sampled on the falling edge.
  int         c_mode1 = 0, c_mode2 = 0, c_wr = 0, c_bad = 0, n_starts = 0;
  logic [1:0] masks [64];
  logic [1:0] prev_mode = 2'd0;
  logic [0:0] last_col2 = 1'b0;

  always @(negedge clk) begin
    if (fsm_mode == 2'd1) c_mode1 <= c_mode1 + 1;
    if (fsm_mode == 2'd2) begin
      c_mode2   <= c_mode2 + 1;
      last_col2 <= fsm_column;
    end
    if (fsm_writing_successful) c_wr <= c_wr + 1;
    if (fsm_mode != 2'd1 && fsm_data_in != 2'd0) c_bad <= c_bad + 1;
    if (fsm_mode == 2'd1 && prev_mode != 2'd1) begin
      masks[n_starts & 63] <= fsm_data_in;
      n_starts <= n_starts + 1;
    end
    prev_mode <= fsm_mode;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int b_m1, b_m2, b_wr, b_st;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic set_reads(input logic [1:0] v0, input logic [1:0] v1,
                           input logic [1:0] v2, input logic [1:0] v3);
    rd_vals[0] = v0;
    rd_vals[1] = v1;
    rd_vals[2] = v2;
    rd_vals[3] = v3;
    rd_base    = rd_cnt;
    b_m1 = c_mode1;
    b_m2 = c_mode2;
    b_wr = c_wr;
    b_st = n_starts;
  endtask

  task automatic send_req(input logic op, input logic [0:0] col, input logic [1:0] data);
    @(negedge clk);
    req_op     = op;
    req_column = col;
    req_data   = data;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    for (int i = 0; i < 400 && !rsp_valid; i++) @(negedge clk);
    #1;
    check({tag, "_rsp_arrived"}, rsp_valid, 1);
  endtask

  task automatic finish_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    int seen;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_op     = 1'b0;
    req_column = 1'b0;
    req_data   = 2'b00;
    rsp_ready  = 1'b0;
    for (int i = 0; i < 8; i++) rd_vals[i] = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_fsm_mode", fsm_mode, 0);
    check("rst_outputs", {rsp_data, rsp_fail, rsp_pulses, fsm_column, fsm_data_in, fsm_writing_successful}, 0);
    reset = 1'b0;

    // Plain read of column 1.
    set_reads(2'b10, 2'b00, 2'b00, 2'b00);
    send_req(1'b0, 1'b1, 2'b00);
    wait_rsp("rd");
    check("rd_data", rsp_data, 2'b10);
    check("rd_fail", rsp_fail, 0);
    check("rd_pulses", rsp_pulses, 0);
    check("rd_column", last_col2, 1);
    check("rd_no_prog", c_mode1 - b_m1, 0);
    finish_rsp();

    // Program 11 on a blank cell.
    set_reads(2'b00, 2'b11, 2'b00, 2'b00);
    send_req(1'b1, 1'b0, 2'b11);
    wait_rsp("pg1");
    check("pg1_prog_cycles", c_mode1 - b_m1, 8);
    check("pg1_mask", masks[b_st & 63], 2'b11);
    check("pg1_wr_pulse", c_wr - b_wr, 1);
    check("pg1_pulses", rsp_pulses, 1);
    check("pg1_fail", rsp_fail, 0);
    check("pg1_data", rsp_data, 2'b11);
    finish_rsp();

    // Partially programmed cell needing two pulses.
    set_reads(2'b01, 2'b01, 2'b11, 2'b00);
    send_req(1'b1, 1'b1, 2'b11);
    wait_rsp("pg2");
    check("pg2_first_mask", masks[b_st & 63], 2'b10);
    check("pg2_pulses", rsp_pulses, 2);
    check("pg2_fail", rsp_fail, 0);
    check("pg2_prog_cycles", c_mode1 - b_m1, 16);
    finish_rsp();

    // Unprogrammable word.
    set_reads(2'b10, 2'b00, 2'b00, 2'b00);
    send_req(1'b1, 1'b0, 2'b01);
    wait_rsp("unp");
    check("unp_fail", rsp_fail, 1);
    check("unp_data", rsp_data, 2'b10);
    check("unp_pulses", rsp_pulses, 0);
    check("unp_no_prog", c_mode1 - b_m1, 0);
    finish_rsp();

    // Already programmed word: success with no pulse.
    set_reads(2'b01, 2'b00, 2'b00, 2'b00);
    send_req(1'b1, 1'b0, 2'b01);
    wait_rsp("done");
    check("done_fail", rsp_fail, 0);
    check("done_pulses", rsp_pulses, 0);
    check("done_no_prog", c_mode1 - b_m1, 0);
    check("done_no_wr", c_wr - b_wr, 0);
    finish_rsp();

    // Verify stuck at 00: retries exhausted.
    set_reads(2'b00, 2'b00, 2'b00, 2'b00);
    send_req(1'b1, 1'b1, 2'b01);
    wait_rsp("stuck");
    check("stuck_fail", rsp_fail, 1);
    check("stuck_pulses", rsp_pulses, 3);
    check("stuck_prog_cycles", c_mode1 - b_m1, 24);
    check("stuck_no_wr", c_wr - b_wr, 0);
    check("stuck_data", rsp_data, 2'b00);
    finish_rsp();

    // Read timeout: controller never answers.
    resp_en = 1'b0;
    set_reads(2'b11, 2'b11, 2'b11, 2'b11);
    send_req(1'b0, 1'b0, 2'b00);
    wait_rsp("tmo");
    check("tmo_fail", rsp_fail, 1);
    check("tmo_data", rsp_data, 2'b00);
    check("tmo_read_cycles", c_mode2 - b_m2, 16);
    finish_rsp();
    resp_en = 1'b1;

    // Reset during the 4th program-pulse cycle.
    set_reads(2'b00, 2'b11, 2'b00, 2'b00);
    send_req(1'b1, 1'b0, 2'b11);
    for (int i = 0; i < 100 && (c_mode1 - b_m1) < 4; i++) begin
      @(negedge clk);
      #1;
    end
    check("rstp_reached_prog", c_mode1 - b_m1, 4);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rstp_mode", fsm_mode, 0);
    check("rstp_req_ready", req_ready, 1);
    check("rstp_rsp_valid", rsp_valid, 0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("rstp_no_rsp", seen, 0);

    // Response held while rsp_ready stays low.
    set_reads(2'b00, 2'b11, 2'b00, 2'b00);
    send_req(1'b1, 1'b1, 2'b11);
    wait_rsp("hold");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_fields", {rsp_data, rsp_fail, rsp_pulses}, {2'b11, 1'b0, 2'd1});
      check("hold_req_ready", req_ready, 0);
    end
    // A request offered in the response exit cycle is not taken.
    @(negedge clk);
    rsp_ready  = 1'b1;
    req_valid  = 1'b1;
    req_op     = 1'b0;
    req_column = 1'b0;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("exit_rsp_valid", rsp_valid, 0);
    check("exit_not_accepted", {req_ready, fsm_mode}, {1'b1, 2'd0});
    @(negedge clk);
    check("no_stray_data_in", c_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/otp_prog_sequencer.md
OTP_PROG_SEQUENCER -- requirements
Module: otp_prog_sequencer

Interface
REQ-001 The module SHALL have parameter A, default 2, meaning OTP rows, which is also the data word width.
REQ-002 The module SHALL have parameter B, default 2, meaning OTP columns; ADDR_WIDTH SHALL equal $clog2(B).
REQ-003 The module SHALL have parameter PULSE_CYCLES, default 8, meaning cycles per program pulse, with a minimum of 1.
REQ-004 The module SHALL have parameter MAX_RETRY, default 3, meaning the program pulses allowed per request, with a minimum of 1.
REQ-005 The module SHALL have parameter READ_TIMEOUT, default 16, meaning the cycles to wait for fsm_read_active before failing.
REQ-006 The module SHALL use one clock; reset is synchronous and active-high; the ports SHALL be clk and reset.
REQ-007 The module SHALL have the following ports, in this order:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_op  in  1  0 = read, 1 = program
- req_column  in  ADDR_WIDTH  target column
- req_data  in  A  bits to program (ignored for read)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_data  out  A  final word read back
- rsp_fail  out  1  operation failed
- rsp_pulses  out  $clog2(MAX_RETRY+1)  program pulses issued
- fsm_mode  out  2  to OTP controller: 0 idle, 1 program, 2 read
- fsm_column  out  ADDR_WIDTH  to controller column
- fsm_data_in  out  A  to controller data_in
- fsm_writing_successful  out  1  to controller; one-cycle pulse
- fsm_read_active  in  1  from controller
- fsm_data_out  in  A  from controller

Function
REQ-008 The state machine SHALL have the states IDLE, PREREAD, PROG, VERIFY and RESP.
REQ-009 In IDLE, req_ready SHALL be 1; when req_valid is 1, the module SHALL latch op, column and data into registers and go to PREREAD on the next cycle.
REQ-010 req_ready SHALL be 0 in every state other than IDLE.
REQ-011 In PREREAD and VERIFY, fsm_mode SHALL be 2 and fsm_column SHALL be the latched column.
REQ-012 In PREREAD and VERIFY, the module SHALL sample fsm_data_out on the first cycle in which fsm_read_active is 1.
REQ-013 If READ_TIMEOUT cycles elapse in PREREAD or VERIFY without fsm_read_active, the module SHALL go to RESP with rsp_fail=1 and rsp_data=0.
REQ-014 After PREREAD, a read op SHALL go to RESP with rsp_fail=0, rsp_data=the sample and rsp_pulses=0.
REQ-015 After PREREAD, a program op SHALL check for bits that are 1 in the sample and 0 in the latched data; any such bit makes the word unprogrammable, and the module SHALL go to RESP with rsp_fail=1, rsp_data=sample and rsp_pulses=0.
REQ-016 After PREREAD, a program op whose (sample & data) == data SHALL go to RESP with rsp_fail=0 and rsp_pulses=0, and SHALL issue no pulse.
REQ-017 Otherwise, a program op SHALL go to PROG with the remaining mask = data & ~sample.
REQ-018 PROG SHALL drive fsm_mode=1 and fsm_data_in=the remaining mask for exactly PULSE_CYCLES cycles, increment the pulse count, then go to VERIFY.
REQ-019 Outside PROG, fsm_data_in SHALL be 0.
REQ-020 A VERIFY sample with (sample & data) == data SHALL pulse fsm_writing_successful for one cycle and go to RESP with rsp_fail=0.
REQ-021 A failing VERIFY with pulses < MAX_RETRY SHALL recompute the mask as data & ~sample and return to PROG.
REQ-022 A failing VERIFY with pulses == MAX_RETRY SHALL go to RESP with rsp_fail=1.
REQ-023 In RESP, rsp_valid SHALL be 1 and rsp_data, rsp_fail and rsp_pulses SHALL be held stable until rsp_ready is 1; in that cycle the module SHALL go to IDLE.
REQ-024 A new request SHALL NOT be accepted in the RESP exit cycle.
REQ-025 fsm_mode SHALL be 0 in the IDLE and RESP states.
REQ-026 The module SHALL register all outputs, except req_ready, which is decoded from the state.

Reset
REQ-027 While reset is 1, on the next clk edge the state SHALL become IDLE, all counters and latched fields SHALL be cleared, and every output SHALL be 0 except req_ready, which SHALL be 1.
REQ-028 Reset asserted mid-PROG SHALL drop fsm_mode to 0 on that edge, and the request SHALL be discarded with no response.

Structure
REQ-029 A shared package otp_pkg SHALL hold the mode encodings MODE_IDLE=0, MODE_PROG=1 and MODE_READ=2, and the state enum typedef.
REQ-030 The module SHALL contain one sub-module, otp_cycle_timer: a loadable down-counter shared by the pulse length and the read timeout.

Verification
REQ-031 Read, column 1, controller returns 2'b10 -> rsp_data=2'b10, rsp_fail=0, rsp_pulses=0, fsm_mode never 1.
REQ-032 Program 2'b11 on a blank cell, verify returns 2'b11 -> exactly 8 cycles of fsm_mode=1 with fsm_data_in=2'b11, one fsm_writing_successful pulse, rsp_pulses=1, rsp_fail=0.
REQ-033 Program 2'b11 with pre-read 2'b01 and verifies returning 2'b01 then 2'b11 -> the first pulse mask is 2'b10, rsp_pulses=2, rsp_fail=0.
REQ-034 Program 2'b01 with pre-read 2'b10 -> immediate fail, rsp_data=2'b10, no PROG cycles.
REQ-035 Verify stuck at 2'b00 for request 2'b01 -> three pulses, rsp_fail=1, rsp_pulses=3; fsm_read_active held 0 -> fail after 16 cycles.
REQ-036 Reset asserted during the 4th PROG cycle -> the next cycle has fsm_mode=0, req_ready=1, rsp_valid=0; rsp_ready held 0 in RESP for 5 cycles -> outputs stable, req_ready=0.
